// File: rtl/ellpack_pkg.sv
// ellpack_pkg: constants and types shared by the ELLPACK row packer and the
// ELLPACK SpMV compute stage.
//   N      rows per matrix
//   L      ELLPACK slots per packed row
//   VAL_W  nonzero value width
//   COL_W  column index width (2^COL_W >= N)
//   ROW_W  row index width
//   CNT_W  width of a slot count 0..L
// Also holds the FILL/EMIT/DONE state encoding and the slot-field offset
// helpers that locate slot s inside a packed value/column bus.
package ellpack_pkg;

    localparam int N     = 494;
    localparam int L     = 10;
    localparam int VAL_W = 32;
    localparam int COL_W = 9;
    localparam int ROW_W = 9;
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_EMIT = 2'd1,
        ST_DONE = 2'd2
    } ellpack_state_e;

    // Bit offset of slot s within out_val / out_col.
    function automatic int val_lsb(input int s);
        return s * VAL_W;
    endfunction

    function automatic int col_lsb(input int s);
        return s * COL_W;
    endfunction

endpackage

// File: rtl/ellpack_row_packer_if.sv
// ellpack_row_packer_if: bundles the CSR input beat stream and the packed
// ELLPACK row output stream.
//   in_*   : one nonzero per beat (value, column, end-of-row, empty-row)
//   out_*  : one packed L-slot row per transfer (values, columns, row, nnz)
// Modports: slave = packer side, master = feeder/consumer side.
//
// Handshake rule for both streams: a transfer happens on a rising clk edge
// where valid && ready are both 1. The source holds valid and its payload
// stable until that edge; the sink may raise or drop ready at any time, and
// ready never depends combinationally on valid.
interface ellpack_row_packer_if;
    import ellpack_pkg::*;

    logic                   in_valid;
    logic                   in_ready;
    logic [VAL_W-1:0]       in_val;
    logic [COL_W-1:0]       in_col;
    logic                   in_last;
    logic                   in_empty;

    logic                   out_valid;
    logic                   out_ready;
    logic [L*VAL_W-1:0]     out_val;
    logic [L*COL_W-1:0]     out_col;
    logic [ROW_W-1:0]       out_row;
    logic [CNT_W-1:0]       out_nnz;

    modport slave (
        input  in_valid, in_val, in_col, in_last, in_empty, out_ready,
        output in_ready, out_valid, out_val, out_col, out_row, out_nnz
    );

    modport master (
        output in_valid, in_val, in_col, in_last, in_empty, out_ready,
        input  in_ready, out_valid, out_val, out_col, out_row, out_nnz
    );

endinterface

// File: rtl/ellpack_row_buf.sv
// ellpack_row_buf: one L-slot row of value/column registers.
//   clk, rst : clock, synchronous active-high reset
//   wr_en    : write wr_val/wr_col into slot[count] and bump count
//   clr      : return every slot to value 0 / column 0 and count to 0
//   vals     : packed slot values, slot s at [s*VAL_W +: VAL_W]
//   cols     : packed slot columns, slot s at [s*COL_W +: COL_W]
//   count    : populated slots 0..L
//   full     : all L slots populated; a write now is an overflow and is dropped
module ellpack_row_buf
    import ellpack_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic                 clr,
    input  logic [VAL_W-1:0]     wr_val,
    input  logic [COL_W-1:0]     wr_col,
    output logic [L*VAL_W-1:0]   vals,
    output logic [L*COL_W-1:0]   cols,
    output logic [CNT_W-1:0]     count,
    output logic                 full
);

    logic [L*VAL_W-1:0] vals_q;
    logic [L*COL_W-1:0] cols_q;
    logic [CNT_W-1:0]   count_q;

    assign full  = (count_q == CNT_W'(L));
    assign vals  = vals_q;
    assign cols  = cols_q;
    assign count = count_q;

    // Clearing on every emit is what keeps unused slots at 0/0 padding.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            vals_q  <= '0;
            cols_q  <= '0;
            count_q <= '0;
        end else if (wr_en && !full) begin
            for (int s = 0; s < L; s++) begin
                if (count_q == CNT_W'(s)) begin
                    vals_q[val_lsb(s) +: VAL_W] <= wr_val;
                    cols_q[col_lsb(s) +: COL_W] <= wr_col;
                end
            end
            count_q <= count_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/ellpack_row_packer.sv
// ellpack_row_packer: packs a CSR beat stream (one nonzero per beat) into
// fixed L-slot ELLPACK rows, emitted in row order 0..N-1.
//   clk, rst  : clock, synchronous active-high reset
//   bus       : ellpack_row_packer_if.slave (input beats, packed row output)
//   overflow  : sticky, some row carried more than L nonzeros
//   done      : all N rows have been emitted
//   state_dbg : current FILL/EMIT/DONE state
// Build option: define ELLPACK_PACK_SKID_EN to add a second row buffer so
// filling continues while a completed row waits for the consumer.
module ellpack_row_packer
    import ellpack_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    ellpack_row_packer_if.slave        bus,
    output logic                       overflow,
    output logic                       done,
    output ellpack_state_e             state_dbg
);

    ellpack_state_e   state_q, state_d;
    logic [ROW_W-1:0] row_q;
    logic             ovf_q;
    logic             ovf_hit;
    logic             hs;
    logic             in_ready;
    logic             out_valid;

`ifdef ELLPACK_PACK_SKID_EN
    logic [1:0]         wr_en_v, clr_v, full_v, full_q, full_d;
    logic               wr_sel_q, wr_sel_d, rd_sel_q, rd_sel_d;
    logic [ROW_W-1:0]   filled_q;
    logic [L*VAL_W-1:0] vals_v [2];
    logic [L*COL_W-1:0] cols_v [2];
    logic [CNT_W-1:0]   cnt_v  [2];

    for (genvar b = 0; b < 2; b++) begin : g_buf
        ellpack_row_buf u_buf (
            .clk    (clk),
            .rst    (rst),
            .wr_en  (wr_en_v[b]),
            .clr    (clr_v[b]),
            .wr_val (bus.in_val),
            .wr_col (bus.in_col),
            .vals   (vals_v[b]),
            .cols   (cols_v[b]),
            .count  (cnt_v[b]),
            .full   (full_v[b])
        );
    end

    // Buffers alternate: wr_sel fills, rd_sel presents. A buffer is "full"
    // from its end-of-row beat until its row is taken by the consumer.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        done      = 1'b0;
        hs        = 1'b0;
        wr_en_v   = 2'b00;
        clr_v     = 2'b00;
        full_d    = full_q;
        wr_sel_d  = wr_sel_q;
        rd_sel_d  = rd_sel_q;
        if (state_q == ST_DONE) begin
            done = 1'b1;
        end else begin
            in_ready  = !full_q[wr_sel_q] && (filled_q != ROW_W'(N));
            out_valid = full_q[rd_sel_q];
            if (bus.in_valid && in_ready) begin
                wr_en_v[wr_sel_q] = !bus.in_empty;
                if (bus.in_last || bus.in_empty) begin
                    full_d[wr_sel_q] = 1'b1;
                    wr_sel_d         = !wr_sel_q;
                end
            end
            if (out_valid && bus.out_ready) begin
                hs               = 1'b1;
                clr_v[rd_sel_q]  = 1'b1;
                full_d[rd_sel_q] = 1'b0;
                rd_sel_d         = !rd_sel_q;
            end
            if (hs && (row_q == ROW_W'(N - 1)))
                state_d = ST_DONE;
            else
                state_d = full_d[rd_sel_d] ? ST_EMIT : ST_FILL;
        end
    end

    assign ovf_hit = |(wr_en_v & full_v);

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q   <= 2'b00;
            wr_sel_q <= 1'b0;
            rd_sel_q <= 1'b0;
            filled_q <= '0;
        end else begin
            full_q   <= full_d;
            wr_sel_q <= wr_sel_d;
            rd_sel_q <= rd_sel_d;
            if (wr_sel_d != wr_sel_q)
                filled_q <= filled_q + ROW_W'(1);
        end
    end

    assign bus.out_val = vals_v[rd_sel_q];
    assign bus.out_col = cols_v[rd_sel_q];
    assign bus.out_nnz = cnt_v[rd_sel_q];
`else
    logic               wr_en, clr, buf_full;
    logic [L*VAL_W-1:0] buf_vals;
    logic [L*COL_W-1:0] buf_cols;
    logic [CNT_W-1:0]   buf_cnt;

    ellpack_row_buf u_buf (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (wr_en),
        .clr    (clr),
        .wr_val (bus.in_val),
        .wr_col (bus.in_col),
        .vals   (buf_vals),
        .cols   (buf_cols),
        .count  (buf_cnt),
        .full   (buf_full)
    );

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        done      = 1'b0;
        hs        = 1'b0;
        wr_en     = 1'b0;
        clr       = 1'b0;
        case (state_q)
            ST_FILL: begin
                in_ready = 1'b1;
                if (bus.in_valid) begin
                    wr_en = !bus.in_empty;
                    // The end-of-row beat's own slot write lands this edge,
                    // so EMIT already presents the complete row.
                    if (bus.in_last || bus.in_empty)
                        state_d = ST_EMIT;
                end
            end
            ST_EMIT: begin
                out_valid = 1'b1;
                if (bus.out_ready) begin
                    hs      = 1'b1;
                    clr     = 1'b1;
                    state_d = (row_q == ROW_W'(N - 1)) ? ST_DONE : ST_FILL;
                end
            end
            ST_DONE: begin
                done = 1'b1;
            end
            default: begin
                state_d = ST_FILL;
            end
        endcase
    end

    assign ovf_hit     = wr_en && buf_full;
    assign bus.out_val = buf_vals;
    assign bus.out_col = buf_cols;
    assign bus.out_nnz = buf_cnt;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FILL;
            row_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (hs)
                row_q <= row_q + ROW_W'(1);
            if (ovf_hit)
                ovf_q <= 1'b1;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_row   = row_q;
    assign overflow      = ovf_q;
    assign state_dbg     = state_q;

endmodule

// File: tb/tb_ellpack_row_packer.sv
// tb_ellpack_row_packer: self-checking bench for ellpack_row_packer.
// A queue-based row model predicts every packed row from the accepted beats;
// one compare process checks handshake flags every cycle and the packed row
// whenever out_valid is expected. Directed rows pin the model with literals.
module tb_ellpack_row_packer;
    import ellpack_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic           overflow;
    logic           done;
    ellpack_state_e state_dbg;

    ellpack_row_packer_if bus();

    logic rdy_random = 1'b0;
    logic rdy_dir    = 1'b1;
    logic rdy_rand   = 1'b1;
    assign bus.out_ready = rdy_random ? rdy_rand : rdy_dir;

    always @(posedge clk) begin
        #1;
        rdy_rand = ($urandom_range(0, 3) != 0);
    end

    ellpack_row_packer dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .overflow  (overflow),
        .done      (done),
        .state_dbg (state_dbg)
    );

    // ---------------- check bookkeeping ----------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard / row model ----------------
    logic [VAL_W-1:0]   cur_v[$];
    logic [COL_W-1:0]   cur_c[$];
    logic [L*VAL_W-1:0] exp_val_q[$];
    logic [L*COL_W-1:0] exp_col_q[$];
    logic [ROW_W-1:0]   exp_row_q[$];
    logic [CNT_W-1:0]   exp_nnz_q[$];
    int  row_next = 0;
    int  emitted  = 0;
    bit  ovf_m    = 1'b0;
    bit  model_on = 1'b0;

    always @(negedge clk) begin : compare
        bit e_valid, e_ready, e_done;
        logic [L*VAL_W-1:0] pv;
        logic [L*COL_W-1:0] pc;
        if (rst) begin
            cur_v.delete(); cur_c.delete();
            exp_val_q.delete(); exp_col_q.delete();
            exp_row_q.delete(); exp_nnz_q.delete();
            row_next = 0;
            emitted  = 0;
            ovf_m    = 1'b0;
            model_on = 1'b1;
        end else if (model_on) begin
            e_done  = (emitted == N);
`ifdef ELLPACK_PACK_SKID_EN
            e_valid = !e_done && (exp_val_q.size() > 0);
            e_ready = !e_done && (exp_val_q.size() < 2) && (row_next < N);
`else
            e_valid = !e_done && (exp_val_q.size() > 0);
            e_ready = !e_done && (exp_val_q.size() == 0);
`endif
            chk("in_ready", bus.in_ready, e_ready);
            chk("out_valid", bus.out_valid, e_valid);
            chk("done", done, e_done);
            chk("overflow", overflow, ovf_m);
            if (e_valid) begin
                chk("out_val", bus.out_val, exp_val_q[0]);
                chk("out_col", bus.out_col, exp_col_q[0]);
                chk("out_row", bus.out_row, exp_row_q[0]);
                chk("out_nnz", bus.out_nnz, exp_nnz_q[0]);
            end
            // Events taking effect at the coming rising edge.
            if (e_valid && bus.out_ready) begin
                void'(exp_val_q.pop_front());
                void'(exp_col_q.pop_front());
                void'(exp_row_q.pop_front());
                void'(exp_nnz_q.pop_front());
                emitted++;
            end
            if (e_ready && bus.in_valid) begin
                if (!bus.in_empty) begin
                    if (cur_v.size() < L) begin
                        cur_v.push_back(bus.in_val);
                        cur_c.push_back(bus.in_col);
                    end else begin
                        ovf_m = 1'b1;
                    end
                end
                if (bus.in_last || bus.in_empty) begin
                    pv = '0;
                    pc = '0;
                    for (int i = 0; i < cur_v.size(); i++) begin
                        pv[i*VAL_W +: VAL_W] = cur_v[i];
                        pc[i*COL_W +: COL_W] = cur_c[i];
                    end
                    exp_val_q.push_back(pv);
                    exp_col_q.push_back(pc);
                    exp_row_q.push_back(ROW_W'(row_next));
                    exp_nnz_q.push_back(CNT_W'(cur_v.size()));
                    row_next++;
                    cur_v.delete();
                    cur_c.delete();
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_beat(input logic [VAL_W-1:0] v, input logic [COL_W-1:0] c,
                             input bit last, input bit empty);
        bit acc;
        int guard;
        bus.in_valid = 1'b1;
        bus.in_val   = v;
        bus.in_col   = c;
        bus.in_last  = last;
        bus.in_empty = empty;
        guard = 0;
        acc   = 1'b0;
        while (!acc && guard < 2000) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            guard++;
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL beat_timeout: in_ready stayed 0 for %0d cycles, required 1", guard);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic send_row(input int n, input bit gaps);
        if (n == 0) begin
            send_beat($urandom, COL_W'($urandom_range(0, 511)), 1'b1, 1'b1);
        end else begin
            for (int i = 0; i < n; i++) begin
                if (gaps && $urandom_range(0, 3) == 0) begin
                    repeat ($urandom_range(1, 2)) @(posedge clk);
                    #1;
                end
                send_beat($urandom, COL_W'($urandom_range(0, 511)), (i == n - 1), 1'b0);
            end
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #5ms;
        checks++;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // ---------------- stimulus ----------------
    initial begin
        int g;
        bus.in_valid = 1'b0;
        bus.in_val   = '0;
        bus.in_col   = '0;
        bus.in_last  = 1'b0;
        bus.in_empty = 1'b0;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset values.
        @(negedge clk);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_in_ready", bus.in_ready, 1'b1);
        chk("rst_overflow", overflow, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_out_row", bus.out_row, 0);
        chk("rst_out_nnz", bus.out_nnz, 0);
        chk("rst_out_val", bus.out_val, 0);
        chk("rst_out_col", bus.out_col, 0);
        chk("rst_state", state_dbg, ST_FILL);
        step();

        // Row 0: three beats, out_ready high.
        rdy_random = 1'b0;
        rdy_dir    = 1'b1;
        send_beat(5, 2, 1'b0, 1'b0);
        send_beat(7, 9, 1'b0, 1'b0);
        send_beat(1, 40, 1'b1, 1'b0);
        @(negedge clk);
        chk("r0_valid", bus.out_valid, 1'b1);
        chk("r0_row", bus.out_row, 0);
        chk("r0_nnz", bus.out_nnz, 3);
        chk("r0_val0", bus.out_val[0*VAL_W +: VAL_W], 5);
        chk("r0_col1", bus.out_col[1*COL_W +: COL_W], 9);
        chk("r0_val2", bus.out_val[2*VAL_W +: VAL_W], 1);
        chk("r0_col2", bus.out_col[2*COL_W +: COL_W], 40);
        chk("r0_pad_val", bus.out_val[L*VAL_W-1:3*VAL_W], 0);
        chk("r0_pad_col", bus.out_col[L*COL_W-1:3*COL_W], 0);
`ifndef ELLPACK_PACK_SKID_EN
        chk("r0_in_ready", bus.in_ready, 1'b0);
`endif
        step();

        // Row 1: empty row.
        send_beat(32'h1234, 77, 1'b1, 1'b1);
        @(negedge clk);
        chk("r1_row", bus.out_row, 1);
        chk("r1_nnz", bus.out_nnz, 0);
        chk("r1_val", bus.out_val, 0);
        chk("r1_col", bus.out_col, 0);
        chk("r1_overflow", overflow, 1'b0);
        step();

        // Row 2: twelve beats, first ten kept.
        for (int i = 1; i <= 12; i++)
            send_beat(i, COL_W'(i), (i == 12), 1'b0);
        @(negedge clk);
        chk("r2_row", bus.out_row, 2);
        chk("r2_nnz", bus.out_nnz, 10);
        chk("r2_val9", bus.out_val[9*VAL_W +: VAL_W], 10);
        chk("r2_col9", bus.out_col[9*COL_W +: COL_W], 10);
        chk("r2_overflow", overflow, 1'b1);
        step();

        // Row 3: consumer stalls for five cycles.
        rdy_dir = 1'b0;
        send_beat(11, 3, 1'b0, 1'b0);
        send_beat(22, 4, 1'b1, 1'b0);
`ifndef ELLPACK_PACK_SKID_EN
        bus.in_valid = 1'b1;
        bus.in_val   = 33;
        bus.in_col   = 5;
        bus.in_last  = 1'b1;
        bus.in_empty = 1'b0;
`endif
        repeat (5) begin
            @(negedge clk);
            chk("stall_valid", bus.out_valid, 1'b1);
            chk("stall_row", bus.out_row, 3);
            chk("stall_val1", bus.out_val[1*VAL_W +: VAL_W], 22);
`ifndef ELLPACK_PACK_SKID_EN
            chk("stall_in_ready", bus.in_ready, 1'b0);
`endif
            step();
        end
        rdy_dir = 1'b1;
`ifndef ELLPACK_PACK_SKID_EN
        send_beat(33, 5, 1'b1, 1'b0);
        @(negedge clk);
        chk("r4_row", bus.out_row, 4);
        chk("r4_nnz", bus.out_nnz, 1);
        chk("r4_overflow_sticky", overflow, 1'b1);
        step();
`endif
        repeat (3) step();

        // Reset in the middle of a row.
        for (int i = 0; i < 4; i++)
            send_beat($urandom, COL_W'($urandom_range(0, 511)), 1'b0, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid", bus.out_valid, 1'b0);
        chk("mid_rst_overflow", overflow, 1'b0);
        chk("mid_rst_nnz", bus.out_nnz, 0);
        step();
        send_beat(44, 6, 1'b0, 1'b0);
        send_beat(55, 7, 1'b1, 1'b0);
        @(negedge clk);
        chk("post_rst_row", bus.out_row, 0);
        chk("post_rst_nnz", bus.out_nnz, 2);
        chk("post_rst_val0", bus.out_val[0*VAL_W +: VAL_W], 44);
        chk("post_rst_col1", bus.out_col[1*COL_W +: COL_W], 7);
        step();

        // Remaining rows of the matrix: back-to-back single beats, then random.
        for (int r = 1; r < N; r++) begin
            if (r < 80) begin
                rdy_random = 1'b0;
                send_row(1, 1'b0);
            end else begin
                rdy_random = 1'b1;
                send_row($urandom_range(0, 13), 1'b1);
            end
        end

        rdy_random = 1'b0;
        rdy_dir    = 1'b1;
        g = 0;
        while (!done && g < 200) begin
            step();
            g++;
        end
        @(negedge clk);
        chk("final_done", done, 1'b1);
        chk("final_in_ready", bus.in_ready, 1'b0);
        chk("final_out_valid", bus.out_valid, 1'b0);
        chk("final_state", state_dbg, ST_DONE);
        chk("final_emitted", emitted, N);
        step();

        // Beats offered after completion must be refused.
        bus.in_valid = 1'b1;
        bus.in_last  = 1'b1;
        bus.in_empty = 1'b0;
        repeat (5) step();
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("hold_done", done, 1'b1);
        chk("hold_emitted", emitted, N);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
